// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: PC register, instruction memory,
// redirect and decode-side signals grouped for the fetch_ctrl block.
interface fetch_ctrl_if;
  logic [31:0] cur_pc;
  logic [31:0] next_pc;
  logic        npc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        pipe_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] stall_cnt;

  modport master (
    input  cur_pc, imem_ready, imem_rdata, pipe_stall,
    input  redirect_valid, redirect_pc, exc_req,
    output next_pc, npc_stall, imem_req, imem_addr,
    output if_valid, if_instr, if_pc, stall_cnt
  );

  modport slave (
    output cur_pc, imem_ready, imem_rdata, pipe_stall,
    output redirect_valid, redirect_pc, exc_req,
    input  next_pc, npc_stall, imem_req, imem_addr,
    input  if_valid, if_instr, if_pc, stall_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: REQ/HOLD/DRAIN FSM, redirects, stall count.
// Ports: CLK, Reset (sync, active-high), bus (fetch_ctrl_if.master).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic         CLK,
  input  logic         Reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        redir;
  logic [31:0] tgt;
  logic [31:0] drain_tgt;

  logic [31:0] next_pc;
  logic        npc_stall;
  logic        imem_req;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  // Exception wins over a branch/jump redirect.
  assign redir = bus.exc_req | bus.redirect_valid;
  assign tgt   = bus.exc_req ? EXC_PC : bus.redirect_pc;

  // A redirect arriving in DRAIN replaces the pending target.
  assign drain_tgt = redir ? tgt : pend_pc_q;

  always_comb begin
    state_d     = state_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    pend_pc_d   = pend_pc_q;
    next_pc     = bus.cur_pc;
    npc_stall   = 1'b0;
    imem_req    = 1'b0;
    if_valid    = 1'b0;
    if_instr    = buf_instr_q;
    if_pc       = buf_pc_q;

    if (Reset) begin
      next_pc = RESET_PC;
    end else begin
      unique case (state_q)
        S_REQ: begin
          imem_req = 1'b1;
          if (redir) begin
            if (bus.imem_ready) begin
              next_pc = tgt;
            end else begin
              pend_pc_d = tgt;
              npc_stall = 1'b1;
              state_d   = S_DRAIN;
            end
          end else if (bus.imem_ready) begin
            if_valid = 1'b1;
            if_instr = bus.imem_rdata;
            if_pc    = bus.cur_pc;
            if (bus.pipe_stall) begin
              buf_instr_d = bus.imem_rdata;
              buf_pc_d    = bus.cur_pc;
              npc_stall   = 1'b1;
              state_d     = S_HOLD;
            end else begin
              next_pc = bus.cur_pc + 32'd4;
            end
          end else begin
            npc_stall = 1'b1;
          end
        end
        S_HOLD: begin
          if (redir) begin
            next_pc = tgt;
            state_d = S_REQ;
          end else if (bus.pipe_stall) begin
            if_valid  = 1'b1;
            npc_stall = 1'b1;
          end else begin
            if_valid = 1'b1;
            next_pc  = buf_pc_q + 32'd4;
            state_d  = S_REQ;
          end
        end
        S_DRAIN: begin
          imem_req  = 1'b1;
          pend_pc_d = drain_tgt;
          if (bus.imem_ready) begin
            next_pc = drain_tgt;
            state_d = S_REQ;
          end else begin
            npc_stall = 1'b1;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // Saturating count of PC-hold cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (npc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_REQ;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.next_pc   = next_pc;
  assign bus.npc_stall = npc_stall;
  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = bus.cur_pc;
  assign bus.if_valid  = if_valid;
  assign bus.if_instr  = if_instr;
  assign bus.if_pc     = if_pc;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and memory models around the DUT,
// per-scenario stimulus rows, delivered-instruction scoreboard.
module tb_fetch_ctrl;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        ps;
    logic        rv;
    logic [31:0] rpc;
    logic        ex;
    logic [2:0]  f;
    logic [31:0] npc;
  } row_t;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_q = 32'h0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] e;
  logic [34:0] o;

  fetch_ctrl_if ifc ();

  fetch_ctrl #(
    .RESET_PC(32'h0000_3000),
    .EXC_PC  (32'h0000_4180)
  ) dut (
    .CLK  (CLK),
    .Reset(rst),
    .bus  (ifc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1F2E};
  endfunction

  assign ifc.cur_pc     = pc_q;
  assign ifc.imem_rdata = imem_word(ifc.imem_addr);

  always @(posedge CLK) begin
    if (!ifc.npc_stall) pc_q <= ifc.next_pc;
  end

  function automatic row_t mk(
    input logic rs, rd, ps, rv,
    input logic [31:0] rpc,
    input logic ex,
    input logic [2:0] f,
    input logic [31:0] npc
  );
    row_t r;
    r = '{rst:rs, rdy:rd, ps:ps, rv:rv, rpc:rpc, ex:ex, f:f, npc:npc};
    return r;
  endfunction

  function automatic logic [34:0] obs();
    return {ifc.imem_req, ifc.npc_stall, ifc.if_valid, ifc.next_pc};
  endfunction

  task automatic cyc(input row_t r);
    @(negedge CLK);
    rst                = r.rst;
    ifc.imem_ready     = r.rdy;
    ifc.pipe_stall     = r.ps;
    ifc.redirect_valid = r.rv;
    ifc.redirect_pc    = r.rpc;
    ifc.exc_req        = r.ex;
    #1;
  endtask

  // f = {imem_req, npc_stall, if_valid}
  task automatic test_reset();
    row_t r[2];
    r[0] = mk(1, 1, 0, 0, 0, 0, 3'b000, 32'h3000);
    r[1] = mk(1, 1, 0, 0, 0, 0, 3'b000, 32'h3000);
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc}) begin
        n_err++;
        $display("FAIL reset[%0d] got %h want %h", i, o, {r[i].f, r[i].npc});
      end
    end
    n_vec++;
    if (ifc.stall_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset_cnt got %h want 0", ifc.stall_cnt);
    end
  endtask

  task automatic test_stream();
    row_t r[3];
    r[0] = mk(0, 1, 0, 0, 0, 0, 3'b101, 32'h3004);
    r[1] = mk(0, 1, 0, 0, 0, 0, 3'b101, 32'h3008);
    r[2] = mk(0, 1, 0, 0, 0, 0, 3'b101, 32'h300C);
    for (int k = 0; k < 3; k++) begin
      sb.push_back({32'h3000 + 32'(4 * k), imem_word(32'h3000 + 32'(4 * k))});
    end
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc}) begin
        n_err++;
        $display("FAIL stream[%0d] got %h want %h", i, o, {r[i].f, r[i].npc});
      end
      if (ifc.if_valid && !ifc.pipe_stall) begin
        n_vec++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        if ({ifc.if_pc, ifc.if_instr} !== e) begin
          n_err++;
          $display("FAIL stream_sb got %h want %h", {ifc.if_pc, ifc.if_instr}, e);
        end
      end
    end
    n_vec++;
    if (sb.size() != 0 || ifc.stall_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL stream_end left %0d cnt %h want 0/0", sb.size(), ifc.stall_cnt);
    end
    sb.delete();
  endtask

  task automatic test_mem_wait();
    row_t r[4];
    r[0] = mk(0, 0, 0, 0, 0, 0, 3'b110, 32'h300C);
    r[1] = mk(0, 0, 0, 0, 0, 0, 3'b110, 32'h300C);
    r[2] = mk(0, 0, 0, 0, 0, 0, 3'b110, 32'h300C);
    r[3] = mk(0, 1, 0, 0, 0, 0, 3'b101, 32'h3010);
    sb.push_back({32'h300C, imem_word(32'h300C)});
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc} || ifc.imem_addr !== 32'h300C) begin
        n_err++;
        $display("FAIL wait[%0d] got %h addr %h want %h addr 300c",
                 i, o, ifc.imem_addr, {r[i].f, r[i].npc});
      end
      if (ifc.if_valid && !ifc.pipe_stall) begin
        n_vec++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        if ({ifc.if_pc, ifc.if_instr} !== e) begin
          n_err++;
          $display("FAIL wait_sb got %h want %h", {ifc.if_pc, ifc.if_instr}, e);
        end
      end
    end
    n_vec++;
    if (sb.size() != 0 || ifc.stall_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL wait_end left %0d cnt %h want 0/3", sb.size(), ifc.stall_cnt);
    end
    sb.delete();
  endtask

  task automatic test_pipe_stall();
    row_t r[3];
    r[0] = mk(0, 1, 1, 0, 0, 0, 3'b111, 32'h3010);
    r[1] = mk(0, 1, 1, 0, 0, 0, 3'b011, 32'h3010);
    r[2] = mk(0, 1, 0, 0, 0, 0, 3'b001, 32'h3014);
    sb.push_back({32'h3010, imem_word(32'h3010)});
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc} ||
          {ifc.if_pc, ifc.if_instr} !== {32'h3010, imem_word(32'h3010)}) begin
        n_err++;
        $display("FAIL hold[%0d] got %h pc %h want %h pc 3010",
                 i, o, ifc.if_pc, {r[i].f, r[i].npc});
      end
      if (ifc.if_valid && !ifc.pipe_stall) begin
        n_vec++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        if ({ifc.if_pc, ifc.if_instr} !== e) begin
          n_err++;
          $display("FAIL hold_sb got %h want %h", {ifc.if_pc, ifc.if_instr}, e);
        end
      end
    end
    n_vec++;
    if (sb.size() != 0 || ifc.stall_cnt !== 32'd5) begin
      n_err++;
      $display("FAIL hold_end left %0d cnt %h want 0/5", sb.size(), ifc.stall_cnt);
    end
    sb.delete();
  endtask

  task automatic test_redirect_drain();
    row_t r[4];
    r[0] = mk(0, 0, 0, 1, 32'h3100, 0, 3'b110, 32'h3014);
    r[1] = mk(0, 0, 0, 0, 32'h0, 0, 3'b110, 32'h3014);
    r[2] = mk(0, 1, 0, 0, 32'h0, 0, 3'b100, 32'h3100);
    r[3] = mk(0, 1, 0, 0, 32'h0, 0, 3'b101, 32'h3104);
    sb.push_back({32'h3100, imem_word(32'h3100)});
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc}) begin
        n_err++;
        $display("FAIL drain[%0d] got %h want %h", i, o, {r[i].f, r[i].npc});
      end
      if (ifc.if_valid && !ifc.pipe_stall) begin
        n_vec++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        if ({ifc.if_pc, ifc.if_instr} !== e) begin
          n_err++;
          $display("FAIL drain_sb got %h want %h", {ifc.if_pc, ifc.if_instr}, e);
        end
      end
    end
    n_vec++;
    if (sb.size() != 0 || ifc.stall_cnt !== 32'd7) begin
      n_err++;
      $display("FAIL drain_end left %0d cnt %h want 0/7", sb.size(), ifc.stall_cnt);
    end
    sb.delete();
  endtask

  task automatic test_exc_hold();
    row_t r[3];
    r[0] = mk(0, 1, 1, 0, 32'h0, 0, 3'b111, 32'h3104);
    r[1] = mk(0, 1, 1, 1, 32'h3200, 1, 3'b000, 32'h4180);
    r[2] = mk(0, 1, 0, 0, 32'h0, 0, 3'b101, 32'h4184);
    sb.push_back({32'h4180, imem_word(32'h4180)});
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc}) begin
        n_err++;
        $display("FAIL exc[%0d] got %h want %h", i, o, {r[i].f, r[i].npc});
      end
      if (ifc.if_valid && !ifc.pipe_stall) begin
        n_vec++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        if ({ifc.if_pc, ifc.if_instr} !== e) begin
          n_err++;
          $display("FAIL exc_sb got %h want %h", {ifc.if_pc, ifc.if_instr}, e);
        end
      end
    end
    n_vec++;
    if (sb.size() != 0 || ifc.stall_cnt !== 32'd8) begin
      n_err++;
      $display("FAIL exc_end left %0d cnt %h want 0/8", sb.size(), ifc.stall_cnt);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back_redirect();
    row_t r[4];
    r[0] = mk(0, 1, 0, 1, 32'h3300, 0, 3'b100, 32'h3300);
    r[1] = mk(0, 0, 0, 1, 32'h3400, 0, 3'b110, 32'h3300);
    r[2] = mk(0, 1, 0, 1, 32'h3500, 0, 3'b100, 32'h3500);
    r[3] = mk(0, 1, 0, 0, 32'h0, 0, 3'b101, 32'h3504);
    sb.push_back({32'h3500, imem_word(32'h3500)});
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc}) begin
        n_err++;
        $display("FAIL b2b[%0d] got %h want %h", i, o, {r[i].f, r[i].npc});
      end
      if (ifc.if_valid && !ifc.pipe_stall) begin
        n_vec++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        if ({ifc.if_pc, ifc.if_instr} !== e) begin
          n_err++;
          $display("FAIL b2b_sb got %h want %h", {ifc.if_pc, ifc.if_instr}, e);
        end
      end
    end
    n_vec++;
    if (sb.size() != 0 || ifc.stall_cnt !== 32'd9) begin
      n_err++;
      $display("FAIL b2b_end left %0d cnt %h want 0/9", sb.size(), ifc.stall_cnt);
    end
    sb.delete();
  endtask

  task automatic test_reset_in_drain();
    row_t r[3];
    r[0] = mk(0, 0, 0, 1, 32'h3100, 0, 3'b110, 32'h3504);
    r[1] = mk(1, 1, 0, 0, 32'h0, 0, 3'b000, 32'h3000);
    r[2] = mk(0, 1, 0, 0, 32'h0, 0, 3'b101, 32'h3004);
    sb.push_back({32'h3000, imem_word(32'h3000)});
    foreach (r[i]) begin
      cyc(r[i]);
      o = obs();
      n_vec++;
      if (o !== {r[i].f, r[i].npc}) begin
        n_err++;
        $display("FAIL rstdrain[%0d] got %h want %h", i, o, {r[i].f, r[i].npc});
      end
      if (ifc.if_valid && !ifc.pipe_stall) begin
        n_vec++;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        if ({ifc.if_pc, ifc.if_instr} !== e) begin
          n_err++;
          $display("FAIL rstdrain_sb got %h want %h", {ifc.if_pc, ifc.if_instr}, e);
        end
      end
    end
    n_vec++;
    if (sb.size() != 0 || ifc.stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rstdrain_end left %0d cnt %h want 0/0", sb.size(), ifc.stall_cnt);
    end
    sb.delete();
  endtask

  initial begin
    ifc.imem_ready     = 1'b0;
    ifc.pipe_stall     = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.exc_req        = 1'b0;
    test_reset();
    test_stream();
    test_mem_wait();
    test_pipe_stall();
    test_redirect_drain();
    test_exc_hold();
    test_back_to_back_redirect();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
